// File: rtl/ncl_rx_pkg.sv
// ---------------------------------------------------------------------------
// ncl_rx_pkg
//   Shared types for the NCL sum-capture receiver.
//   - rx_state_e : receiver handshake state (waiting for DATA / waiting for NULL)
//   - dr_class_e : classification of one dual-rail digit
//   - dr_class() : maps a {rail1, rail0} pair to its class
// ---------------------------------------------------------------------------
package ncl_rx_pkg;

    typedef enum logic {
        WAIT_DATA = 1'b0,
        WAIT_NULL = 1'b1
    } rx_state_e;

    typedef enum logic [1:0] {
        DR_NULL    = 2'd0,
        DR_DATA    = 2'd1,
        DR_ILLEGAL = 2'd2
    } dr_class_e;

    // pair = {rail1, rail0}
    function automatic dr_class_e dr_class(input logic [1:0] pair);
        dr_class_e c;
        case (pair)
            2'b00:   c = DR_NULL;
            2'b11:   c = DR_ILLEGAL;
            default: c = DR_DATA;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ncl_dr_sync.sv
// ---------------------------------------------------------------------------
// ncl_dr_sync
//   Synchronises one dual-rail digit into the capture clock domain and
//   classifies it. Each rail passes SYNC_STAGES flops; the last stage is
//   compared with its value one cycle earlier so that a digit is only
//   reported once its synced pair has been stable for a full cycle.
// Ports
//   clk     in   capture clock
//   rst     in   asynchronous active-high reset
//   rail    in   {rail1, rail0} of the digit (asynchronous to clk)
//   stable  out  synced pair equals its previous-cycle value
//   cls     out  class of the synced pair (NULL / DATA / ILLEGAL)
//   value   out  rail1 of the synced pair (single-rail data bit)
// ---------------------------------------------------------------------------
module ncl_dr_sync
    import ncl_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] rail,
    output logic       stable,
    output dr_class_e  cls,
    output logic       value
);

    logic [SYNC_STAGES-1:0][1:0] sync_q;
    logic [SYNC_STAGES-1:0][1:0] sync_d;
    logic [1:0]                  prev_q;
    logic [1:0]                  prev_d;

    // Rails are monotonic within a wavefront, so each rail is synchronised on
    // its own; the stability compare hides any skew between the two chains.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], rail};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    // ---- classification of the last sync stage ----
    assign stable = (sync_q[SYNC_STAGES-1] == prev_q);
    assign cls    = dr_class(sync_q[SYNC_STAGES-1]);
    assign value  = sync_q[SYNC_STAGES-1][1];

endmodule

// File: rtl/ncl_sum_capture.sv
// ---------------------------------------------------------------------------
// ncl_sum_capture
//   Clocked receiver for the dual-rail sum of the NCL two-D counter. Drives
//   per-digit completion (sumcomp) back upstream and presents every complete
//   DATA wavefront as a single-rail word on a valid/ready port.
// Ports
//   clk        in   capture clock
//   init       in   asynchronous active-high reset (shared with the counter ring)
//   sum_dr     in   dual-rail digits, digit k on [2k+1:2k], [2k+1] = rail1
//   sumcomp    out  per-digit completion: 1 = DATA accepted, 0 = request DATA
//   out_data   out  captured word, bit k = rail1 of digit k
//   out_valid  out  out_data holds an unconsumed word
//   out_ready  in   sink accepts out_data when out_valid && out_ready
//   err        out  sticky protocol error
// Build option
//   NCL_SUM_CAPTURE_ERR_EN : enables ILLEGAL-digit and wavefront-overrun
//   detection on err. Without it err is tied low and an ILLEGAL digit simply
//   stalls the handshake until it becomes legal.
// ---------------------------------------------------------------------------
module ncl_sum_capture
    import ncl_rx_pkg::*;
#(
    parameter int DIGITS      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                init,
    input  logic [2*DIGITS-1:0] sum_dr,
    output logic [DIGITS-1:0]   sumcomp,
    output logic [DIGITS-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                err
);

    logic [DIGITS-1:0] dig_stable;
    logic [DIGITS-1:0] dig_val;
    dr_class_e         dig_cls [DIGITS];
    logic [DIGITS-1:0] dig_data;
    logic [DIGITS-1:0] dig_null;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        ncl_dr_sync #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk    (clk),
            .rst    (init),
            .rail   (sum_dr[2*g+1:2*g]),
            .stable (dig_stable[g]),
            .cls    (dig_cls[g]),
            .value  (dig_val[g])
        );
    end

    // ---- completeness trees over stable digit classes ----
    always_comb begin
        dig_data = '0;
        dig_null = '0;
        for (int k = 0; k < DIGITS; k++) begin
            dig_data[k] = dig_stable[k] && (dig_cls[k] == DR_DATA);
            dig_null[k] = dig_stable[k] && (dig_cls[k] == DR_NULL);
        end
    end

    logic all_data;
    logic all_null;
    assign all_data = &dig_data;
    assign all_null = &dig_null;

    // ---- handshake FSM and output buffer ----
    rx_state_e         state_q,     state_d;
    logic [DIGITS-1:0] sumcomp_q,   sumcomp_d;
    logic [DIGITS-1:0] out_data_q,  out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              capture;

    // A word is only taken into a free (or simultaneously drained) buffer, so
    // a full buffer stalls upstream on DATA instead of overwriting.
    assign capture = (state_q == WAIT_DATA) && all_data && (!out_valid_q || out_ready);

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            state_q     <= WAIT_DATA;
            sumcomp_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sumcomp_q   <= sumcomp_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_DATA: if (capture)  state_d = WAIT_NULL;
            WAIT_NULL: if (all_null) state_d = WAIT_DATA;
            default:                 state_d = WAIT_DATA;
        endcase
    end

    always_comb begin
        sumcomp_d   = sumcomp_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q && !out_ready;
        if (capture) begin
            out_data_d  = dig_val;
            out_valid_d = 1'b1;
            sumcomp_d   = '1;
        end
        if ((state_q == WAIT_NULL) && all_null) begin
            sumcomp_d = '0;
        end
    end

    // sumcomp comes straight from one register, so all bits switch together.
    assign sumcomp   = sumcomp_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

`ifdef NCL_SUM_CAPTURE_ERR_EN
    // ---- protocol error detection ----
    logic [DIGITS-1:0] dig_ill;
    logic [DIGITS-1:0] seen_null_q, seen_null_d;
    logic              err_q,       err_d;
    logic              overrun;

    always_comb begin
        dig_ill = '0;
        for (int k = 0; k < DIGITS; k++) begin
            dig_ill[k] = dig_stable[k] && (dig_cls[k] == DR_ILLEGAL);
        end
    end

    // Digits that already reached NULL in this return-to-null phase; one of
    // them showing DATA again means the next wavefront overran the handshake.
    assign overrun = (state_q == WAIT_NULL) && |(seen_null_q & dig_data);

    always_comb begin
        seen_null_d = '0;
        if (state_q == WAIT_NULL) begin
            seen_null_d = seen_null_q | dig_null;
        end
        err_d = err_q | (|dig_ill) | overrun;
    end

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            seen_null_q <= '0;
            err_q       <= 1'b0;
        end else begin
            seen_null_q <= seen_null_d;
            err_q       <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
